// File: rtl/block_scheduler.sv
// Falling-block launch scheduler: plays a lane-mask/gap pattern against frame ticks.
// Define BLOCK_SCHED_LOOP_EN to wrap the pattern forever instead of draining.
module block_scheduler #(
  parameter int NUM_LANES   = 5,
  parameter int PATTERN_LEN = 16,
  localparam int AW = $clog2(PATTERN_LEN)
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_run,
  input  logic                 i_frame_clk,
  input  logic [NUM_LANES-1:0] i_block_done,
  output logic [AW-1:0]        o_pattern_addr,
  input  logic [8:0]           i_pattern_data,
  output logic [NUM_LANES-1:0] o_block_ready,
  output logic [7:0]           o_overrun_cnt,
  output logic                 o_busy,
  output logic                 o_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_LAUNCH,
    S_WAIT,
    S_PAUSE,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic                 r_sync1;
  logic                 r_sync2;
  logic                 r_sync3;
  logic                 r_tick;
  logic [AW-1:0]        r_addr;
  logic [3:0]           r_gap_cnt;
  logic [NUM_LANES-1:0] r_mask;
  logic [NUM_LANES-1:0] r_ready;
  logic [7:0]           r_ovr;

  logic [NUM_LANES-1:0] w_mask_in;
  logic [NUM_LANES-1:0] w_refused;
  logic [8:0]           w_nref;
  logic [8:0]           w_sum;
  logic                 w_last;
  logic                 w_launch;
  logic                 w_step;

  // frame_clk crosses domains: two sync flops, then a registered edge pulse
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_sync3 <= 1'b0;
      r_tick  <= 1'b0;
    end else begin
      r_sync1 <= i_frame_clk;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
      r_tick  <= r_sync2 & ~r_sync3;
    end
  end

  always_comb begin
    w_mask_in = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (i < 5) w_mask_in[i] = i_pattern_data[4+i];
    end
  end

  assign w_last   = (r_addr == AW'(PATTERN_LEN - 1));
  assign w_launch = (r_state == S_LAUNCH);
  assign w_step   = (r_state == S_WAIT) && i_run && r_tick;

  // a lane freed in the launch cycle is relaunched, not refused
  assign w_refused = w_launch ? (r_mask & r_ready & ~i_block_done) : '0;

  always_comb begin
    w_nref = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      w_nref = w_nref + 9'(w_refused[i]);
    end
  end

  assign w_sum = {1'b0, r_ovr} + w_nref;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:   if (i_run) w_next = S_LOAD;
      S_LOAD:   w_next = S_LAUNCH;
      S_LAUNCH: w_next = S_WAIT;
      S_WAIT: begin
        if (!i_run) begin
          w_next = S_PAUSE;
        end else if (r_tick && r_gap_cnt == 4'd1) begin
`ifdef BLOCK_SCHED_LOOP_EN
          w_next = S_LOAD;
`else
          w_next = w_last ? S_DRAIN : S_LOAD;
`endif
        end
      end
      S_PAUSE:  if (i_run) w_next = S_WAIT;
      S_DRAIN:  if (r_ready == '0) w_next = S_DONE;
      S_DONE:   if (!i_run) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_addr    <= '0;
      r_gap_cnt <= '0;
      r_mask    <= '0;
    end else begin
      if (r_state == S_IDLE) r_addr <= '0;
      if (r_state == S_LOAD) begin
        r_mask    <= w_mask_in;
        r_gap_cnt <= (i_pattern_data[3:0] == 4'd0) ? 4'd1
                                                   : i_pattern_data[3:0];
      end
      if (w_step) begin
        if (r_gap_cnt == 4'd1) begin
          if (!w_last) begin
            r_addr <= r_addr + AW'(1);
          end else begin
`ifdef BLOCK_SCHED_LOOP_EN
            r_addr <= '0;
`else
            r_addr <= r_addr;
`endif
          end
        end else begin
          r_gap_cnt <= r_gap_cnt - 4'd1;
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ready <= '0;
      r_ovr   <= '0;
    end else begin
      r_ready <= (r_ready & ~i_block_done) | (w_launch ? r_mask : '0);
      if (w_launch) r_ovr <= w_sum[8] ? 8'hFF : w_sum[7:0];
    end
  end

  assign o_pattern_addr = r_addr;
  assign o_block_ready  = r_ready;
  assign o_overrun_cnt  = r_ovr;
  assign o_busy = (r_state == S_LOAD)  || (r_state == S_LAUNCH) ||
                  (r_state == S_WAIT)  || (r_state == S_PAUSE)  ||
                  (r_state == S_DRAIN);
  assign o_done = (r_state == S_DONE);

endmodule
